// File: rtl/fpga_avmm_write_master_pkg.sv
// Shared types and helpers for the FPGA-side Avalon-MM write master.
package fpga_avmm_write_master_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StWrite
  } wm_state_e;

  function automatic int unsigned bytes_per_word(int unsigned data_w);
    return data_w / 8;
  endfunction

  // Byte address of the last word in the circular window.
  function automatic longint unsigned window_end_addr(longint unsigned base,
                                                     int unsigned     words,
                                                     int unsigned     bpw);
    return base + 64'(words - 1) * 64'(bpw);
  endfunction

endpackage

// File: rtl/fpga_avmm_wm_fifo.sv
// Synchronous show-ahead FIFO with flush; full/empty come from registered pointers.
module fpga_avmm_wm_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic               do_push, do_pop;

  assign full    = (wptr_q[PtrW] != rptr_q[PtrW]) && (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q[PtrW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + (PtrW+1)'(1);
      if (do_pop)  rptr_d = rptr_q + (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wptr_q[PtrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fpga_avmm_write_master.sv
// Avalon-MM write master: buffers stream words and writes them to a circular address window.
// Optional statistics outputs (wr_count, stall_seen) are built when FPGA_AVMM_WM_STATS_EN is defined.
module fpga_avmm_write_master
  import fpga_avmm_write_master_pkg::*;
#(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int unsigned       WORDS      = 16,
  parameter int unsigned       FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  output logic                busy,
  output logic                wrap
`ifdef FPGA_AVMM_WM_STATS_EN
  ,
  output logic [15:0]         wr_count,
  output logic                stall_seen
`endif
);

  localparam int unsigned       BytesPerWord = bytes_per_word(DATA_W);
  localparam logic [ADDR_W-1:0] AddrStep     = ADDR_W'(BytesPerWord);
  localparam logic [ADDR_W-1:0] EndAddr      =
      ADDR_W'(window_end_addr(64'(BASE_ADDR), WORDS, BytesPerWord));

  wm_state_e         state_q, state_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              clear_pend_q, clear_pend_d;

  logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic              accept, at_end, clear_eff;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && !fifo_full && !clear;
  assign accept    = write_q && !avm_waitrequest;
  assign at_end    = (addr_q == EndAddr);
  // A clear seen while a write is stalled is held until that write is accepted.
  assign clear_eff = clear || clear_pend_q;

  fpga_avmm_wm_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .wdata   (in_data),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    data_d       = data_q;
    addr_d       = addr_q;
    clear_pend_d = clear_pend_q;
    fifo_pop     = 1'b0;
    fifo_flush   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clear) begin
          fifo_flush = 1'b1;
          addr_d     = BASE_ADDR;
        end else if (enable && !fifo_empty) begin
          fifo_pop = 1'b1;
          data_d   = fifo_rdata;
          write_d  = 1'b1;
          state_d  = StWrite;
        end
      end
      StWrite: begin
        if (!accept) begin
          if (clear) clear_pend_d = 1'b1;
        end else if (clear_eff) begin
          fifo_flush   = 1'b1;
          addr_d       = BASE_ADDR;
          write_d      = 1'b0;
          clear_pend_d = 1'b0;
          state_d      = StIdle;
        end else begin
          addr_d = at_end ? BASE_ADDR : addr_q + AddrStep;
          if (enable && !fifo_empty) begin
            fifo_pop = 1'b1;
            data_d   = fifo_rdata;
          end else begin
            write_d = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      write_q      <= 1'b0;
      data_q       <= '0;
      addr_q       <= BASE_ADDR;
      clear_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      data_q       <= data_d;
      addr_q       <= addr_d;
      clear_pend_q <= clear_pend_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_write      = write_q;
  assign avm_writedata  = data_q;
  assign avm_byteenable = '1;
  assign busy           = !fifo_empty || write_q;
  assign wrap           = accept && at_end;

`ifdef FPGA_AVMM_WM_STATS_EN
  logic [15:0] wr_count_q;
  logic        stall_seen_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_count_q   <= '0;
      stall_seen_q <= 1'b0;
    end else if (clear) begin
      wr_count_q   <= '0;
      stall_seen_q <= 1'b0;
    end else begin
      if (accept && (wr_count_q != 16'hFFFF)) wr_count_q <= wr_count_q + 16'd1;
      if (write_q && avm_waitrequest) stall_seen_q <= 1'b1;
    end
  end

  assign wr_count   = wr_count_q;
  assign stall_seen = stall_seen_q;
`endif

endmodule

// File: tb/tb_fpga_avmm_write_master.sv
// Self-checking bench: directed steps plus random traffic against a queue-based write model.
module tb_fpga_avmm_write_master;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 16;
  localparam logic [15:0] BASE  = 16'h0040;
  localparam int unsigned WORDS = 4;
  localparam int unsigned DEPTH = 4;

  logic          clk, reset_n, enable, clear, in_valid, in_ready;
  logic [DW-1:0] in_data, avm_writedata;
  logic [AW-1:0] avm_address;
  logic          avm_write, avm_waitrequest, busy, wrap;
  logic [3:0]    avm_byteenable;
`ifdef FPGA_AVMM_WM_STATS_EN
  logic [15:0]   wr_count;
  logic          stall_seen;
`endif

  fpga_avmm_write_master #(
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .BASE_ADDR  (BASE),
    .WORDS      (WORDS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .clear           (clear),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .avm_address     (avm_address),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .wrap            (wrap)
`ifdef FPGA_AVMM_WM_STATS_EN
    ,
    .wr_count        (wr_count),
    .stall_seen      (stall_seen)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: words owed to the bus in order, and the window slot of the next write.
  logic [31:0] mq[$];
  int          idx = 0;
  bit          pend = 0;
  int          wraps = 0;
  int          cnt_m = 0;
  bit          stall_m = 0;
  logic [31:0] last_data = '0;
  logic [15:0] last_addr = '0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [31:0] prev_data = '0;

  function automatic logic [15:0] exp_addr(int i);
    return BASE + 16'(i * 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample just before each rising edge: what is visible now happens at that edge.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_write", 32'(avm_write), 32'd1);
        chk("hold_addr", 32'(avm_address), 32'(prev_addr));
        chk("hold_data", avm_writedata, prev_data);
      end
      prev_stall = avm_write && avm_waitrequest;
      prev_addr  = avm_address;
      prev_data  = avm_writedata;
      if (in_valid && in_ready && !clear) mq.push_back(in_data);
      if (clear) begin
        if (avm_write) pend = 1;
        else begin
          mq.delete();
          idx = 0;
        end
      end
      if (avm_write && !avm_waitrequest) begin
        if (mq.size() == 0) begin
          n_cmp++;
          n_err++;
          $error("FAIL unexpected_write: observed data %0h expected no write", avm_writedata);
        end else begin
          e = mq.pop_front();
          chk("wr_data", avm_writedata, e);
          chk("wr_addr", 32'(avm_address), 32'(exp_addr(idx)));
          chk("wr_wrap", 32'(wrap), 32'(idx == int'(WORDS) - 1));
          if (idx == int'(WORDS) - 1) wraps++;
        end
        last_data = avm_writedata;
        last_addr = avm_address;
        idx = (idx + 1) % int'(WORDS);
        if (pend) begin
          mq.delete();
          idx  = 0;
          pend = 0;
        end
      end else begin
        chk("wrap_idle", 32'(wrap), 32'd0);
      end
      if (clear) cnt_m = 0;
      else if (avm_write && !avm_waitrequest && cnt_m < 65535) cnt_m++;
      if (clear) stall_m = 0;
      else if (avm_write && avm_waitrequest) stall_m = 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("push_ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int w0;
    reset_n = 1'b0;
    enable = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    avm_waitrequest = 1'b0;
    #12;
    chk("rst_write", 32'(avm_write), 32'd0);
    chk("rst_data", avm_writedata, 32'd0);
    chk("rst_addr", 32'(avm_address), 32'(BASE));
    chk("rst_wrap", 32'(wrap), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_be", 32'(avm_byteenable), 32'hF);
    tick();
    reset_n = 1'b1;
    tick();
    enable = 1'b1;

    // Single word, no stall: write appears 2 cycles after the push.
    in_valid = 1'b1;
    in_data = 32'hA5A5_0001;
    tick();
    in_valid = 1'b0;
    chk("s1_lat1_write", 32'(avm_write), 32'd0);
    chk("s1_lat1_busy", 32'(busy), 32'd1);
    tick();
    chk("s1_write", 32'(avm_write), 32'd1);
    chk("s1_addr", 32'(avm_address), 32'(BASE));
    chk("s1_data", avm_writedata, 32'hA5A5_0001);
    tick();
    chk("s1_done_write", 32'(avm_write), 32'd0);
    chk("s1_done_busy", 32'(busy), 32'd0);

    // Stall hold for 5 cycles, then acceptance advances the address by 4.
    avm_waitrequest = 1'b1;
    push_word(32'hB000_0002);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_write", 32'(avm_write), 32'd1);
      chk("stall_addr", 32'(avm_address), 32'(BASE + 16'd4));
      chk("stall_data", avm_writedata, 32'hB000_0002);
      tick();
    end
    avm_waitrequest = 1'b0;
    tick();
    chk("stall_done_write", 32'(avm_write), 32'd0);
    chk("stall_next_addr", 32'(avm_address), 32'(BASE + 16'd8));
`ifdef FPGA_AVMM_WM_STATS_EN
    chk("stat_stall_seen", 32'(stall_seen), 32'(stall_m));
`endif

    // Fill the FIFO with enable low, then drain back-to-back.
    enable = 1'b0;
    for (int i = 0; i < 4; i++) push_word(32'hC000_0000 + 32'(i));
    chk("full_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data = 32'hDEAD_BEEF;
    tick();
    in_valid = 1'b0;
    chk("full_still", 32'(in_ready), 32'd0);
    chk("full_nowrite", 32'(avm_write), 32'd0);
    enable = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("b2b_write", 32'(avm_write), 32'd1);
      tick();
    end
    chk("b2b_end", 32'(avm_write), 32'd0);
    chk("b2b_wraps", 32'(wraps), 32'd1);

    // Clear in idle, then 5 words: wrap at BASE+12, fifth write lands on BASE.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_idle_addr", 32'(avm_address), 32'(BASE));
    w0 = wraps;
    for (int i = 0; i < 5; i++) push_word(32'h5000_0000 + 32'(i));
    wait_idle(50);
    chk("wrap_delta", 32'(wraps - w0), 32'd1);
    chk("wrap_last_addr", 32'(last_addr), 32'(BASE));
    chk("wrap_last_data", last_data, 32'h5000_0004);

    // Clear while the first of 3 queued writes is stalled.
    enable = 1'b0;
    for (int i = 0; i < 3; i++) push_word(32'hD000_0000 + 32'(i));
    avm_waitrequest = 1'b1;
    enable = 1'b1;
    tick();
    chk("cmw_write", 32'(avm_write), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    chk("cmw_hold_write", 32'(avm_write), 32'd1);
    chk("cmw_hold_data", avm_writedata, 32'hD000_0000);
    avm_waitrequest = 1'b0;
    tick();
    chk("cmw_idle_write", 32'(avm_write), 32'd0);
    chk("cmw_idle_busy", 32'(busy), 32'd0);
    chk("cmw_addr", 32'(avm_address), 32'(BASE));
    push_word(32'hE000_0000);
    wait_idle(20);
    chk("cmw_next_addr", 32'(last_addr), 32'(BASE));
    chk("cmw_next_data", last_data, 32'hE000_0000);

    // Enable low holds queued words; writes resume within 2 cycles of enable.
    enable = 1'b0;
    push_word(32'hF000_0000);
    push_word(32'hF000_0001);
    for (int i = 0; i < 5; i++) begin
      chk("en_low_write", 32'(avm_write), 32'd0);
      tick();
    end
    enable = 1'b1;
    n = 0;
    while (!avm_write && n < 2) begin
      tick();
      n++;
    end
    chk("en_resume", 32'(avm_write), 32'd1);
    wait_idle(20);
    chk("en_last_data", last_data, 32'hF000_0001);

    // Random traffic with stalls, enable drops and occasional clears.
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = $urandom;
      avm_waitrequest = ($urandom_range(0, 3) == 0);
      enable = ($urandom_range(0, 15) != 0);
      clear = ($urandom_range(0, 63) == 0);
      tick();
    end
    in_valid = 1'b0;
    clear = 1'b0;
    avm_waitrequest = 1'b0;
    enable = 1'b1;
    tick();
    wait_idle(100);
    chk("rand_model_empty", 32'(mq.size()), 32'd0);
`ifdef FPGA_AVMM_WM_STATS_EN
    chk("stat_wr_count", 32'(wr_count), 32'(cnt_m));
    chk("stat_stall_end", 32'(stall_seen), 32'(stall_m));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
